// File: rtl/mem_to_graphics_buffered_if.sv
// Request, bounds-check and VRAM drain signals of the buffered graphics/text memory adapter.
// A write-port transfer happens on a cycle where valid and ready are both high. While valid is high and
// ready is low, the source holds valid, addr and data unchanged. ready may depend on nothing from the source.
interface mem_to_graphics_buffered_if #(
   parameter int ADDR_W     = 32,
   parameter int DATA_BYTES = 4
);
   logic [ADDR_W-1:0]       req_addr;
   logic [8*DATA_BYTES-1:0] req_data;
   logic [DATA_BYTES-1:0]   req_data_en;
   logic                    req_write_en;
   logic                    req_read_en;
   logic                    req_hit;
   logic                    req_done;

   logic [ADDR_W-1:0]       chk_addr;
   logic                    chk_in_bounds;

   logic [ADDR_W-1:0]       gfx_addr;
   logic [8*DATA_BYTES-1:0] gfx_data;
   logic                    gfx_valid;
   logic                    gfx_ready;

   logic [ADDR_W-1:0]       txt_addr;
   logic [7:0]              txt_data;
   logic                    txt_valid;
   logic                    txt_ready;

   modport master (
      output req_addr, req_data, req_data_en, req_write_en, req_read_en, chk_addr, gfx_ready, txt_ready,
      input  req_hit, req_done, chk_in_bounds, gfx_addr, gfx_data, gfx_valid, txt_addr, txt_data, txt_valid
   );

   modport slave (
      input  req_addr, req_data, req_data_en, req_write_en, req_read_en, chk_addr, gfx_ready, txt_ready,
      output req_hit, req_done, chk_in_bounds, gfx_addr, gfx_data, gfx_valid, txt_addr, txt_data, txt_valid
   );
endinterface

// File: rtl/mem_to_graphics_buffered.sv
// Buffered framebuffer / text-VRAM write adapter with per-region FIFOs and a text byte serialiser.
// Optional MEM_TO_GFX_PERF_EN adds saturating gfx_wr_count, txt_wr_count and stall_count outputs.
module mem_to_graphics_buffered #(
   parameter int                ADDR_W     = 32,
   parameter int                DATA_BYTES = 4,
   parameter logic [ADDR_W-1:0] GFX_BASE   = '0,
   parameter logic [ADDR_W-1:0] GFX_SIZE   = '0,
   parameter logic [ADDR_W-1:0] TXT_BASE   = '0,
   parameter logic [ADDR_W-1:0] TXT_SIZE   = '0,
   parameter int                FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   mem_to_graphics_buffered_if.slave     bus,
   output logic [0:0]                    txt_fsm_state
`ifdef MEM_TO_GFX_PERF_EN
   ,
   output logic [31:0]                   gfx_wr_count,
   output logic [31:0]                   txt_wr_count,
   output logic [31:0]                   stall_count
`endif
);

   localparam int GFX_SHIFT = $clog2(DATA_BYTES);
   localparam int LANE_W    = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
   localparam int PTR_W     = $clog2(FIFO_DEPTH);
   localparam int CNT_W     = PTR_W + 1;
   localparam int DW        = 8 * DATA_BYTES;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      EMIT = 1'b1
   } txt_state_e;

   function automatic logic in_region(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] base,
                                      input logic [ADDR_W-1:0] size);
      return (a >= base) && ((a - base) < size);
   endfunction

   // Decode; on overlap the framebuffer claims the address.
   logic in_gfx, in_txt;
   assign in_gfx = in_region(bus.req_addr, GFX_BASE, GFX_SIZE);
   assign in_txt = !in_gfx && in_region(bus.req_addr, TXT_BASE, TXT_SIZE);
   assign bus.chk_in_bounds = in_region(bus.chk_addr, GFX_BASE, GFX_SIZE) ||
                              in_region(bus.chk_addr, TXT_BASE, TXT_SIZE);

   logic [CNT_W-1:0] gfx_cnt, txt_cnt;
   logic             gfx_full, txt_full;
   logic             gfx_push, gfx_pop, txt_push, txt_pop;

   assign gfx_full = (gfx_cnt == CNT_W'(FIFO_DEPTH));
   assign txt_full = (txt_cnt == CNT_W'(FIFO_DEPTH));
   assign gfx_push = bus.req_write_en && in_gfx && !gfx_full;
   assign txt_push = bus.req_write_en && in_txt && !txt_full;

   assign bus.req_hit = (bus.req_read_en && (in_gfx || in_txt)) || gfx_push || txt_push;

   always_ff @(posedge clk) begin
      if (!reset) bus.req_done <= 1'b0;
      else        bus.req_done <= bus.req_hit;
   end

   // Framebuffer FIFO: the head drives the port directly.
   logic [ADDR_W-1:0] gfx_addr_mem [FIFO_DEPTH];
   logic [DW-1:0]     gfx_data_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  gfx_wr_ptr, gfx_rd_ptr;

   always_ff @(posedge clk) begin
      if (gfx_push) begin
         gfx_addr_mem[gfx_wr_ptr] <= ADDR_W'((bus.req_addr - GFX_BASE) >> GFX_SHIFT);
         gfx_data_mem[gfx_wr_ptr] <= bus.req_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         gfx_wr_ptr <= '0;
         gfx_rd_ptr <= '0;
         gfx_cnt    <= '0;
      end else begin
         if (gfx_push) gfx_wr_ptr <= gfx_wr_ptr + PTR_W'(1);
         if (gfx_pop)  gfx_rd_ptr <= gfx_rd_ptr + PTR_W'(1);
         case ({gfx_push, gfx_pop})
            2'b10:   gfx_cnt <= gfx_cnt + CNT_W'(1);
            2'b01:   gfx_cnt <= gfx_cnt - CNT_W'(1);
            default: gfx_cnt <= gfx_cnt;
         endcase
      end
   end

   assign bus.gfx_valid = (gfx_cnt != '0);
   assign bus.gfx_addr  = gfx_addr_mem[gfx_rd_ptr];
   assign bus.gfx_data  = gfx_data_mem[gfx_rd_ptr];
   assign gfx_pop       = bus.gfx_valid && bus.gfx_ready;

   // Text FIFO holds the byte offset, full word and lane enables.
   logic [ADDR_W-1:0]     txt_off_mem [FIFO_DEPTH];
   logic [DW-1:0]         txt_data_mem [FIFO_DEPTH];
   logic [DATA_BYTES-1:0] txt_en_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      txt_wr_ptr, txt_rd_ptr;

   always_ff @(posedge clk) begin
      if (txt_push) begin
         txt_off_mem[txt_wr_ptr]  <= bus.req_addr - TXT_BASE;
         txt_data_mem[txt_wr_ptr] <= bus.req_data;
         txt_en_mem[txt_wr_ptr]   <= bus.req_data_en;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         txt_wr_ptr <= '0;
         txt_rd_ptr <= '0;
         txt_cnt    <= '0;
      end else begin
         if (txt_push) txt_wr_ptr <= txt_wr_ptr + PTR_W'(1);
         if (txt_pop)  txt_rd_ptr <= txt_rd_ptr + PTR_W'(1);
         case ({txt_push, txt_pop})
            2'b10:   txt_cnt <= txt_cnt + CNT_W'(1);
            2'b01:   txt_cnt <= txt_cnt - CNT_W'(1);
            default: txt_cnt <= txt_cnt;
         endcase
      end
   end

   // Lanes that run past the end of text VRAM are dropped when the head is loaded.
   logic [DATA_BYTES-1:0] head_mask;
   logic [ADDR_W:0]       lane_end;
   always_comb begin
      head_mask = '0;
      lane_end  = '0;
      for (int l = 0; l < DATA_BYTES; l++) begin
         lane_end     = {1'b0, txt_off_mem[txt_rd_ptr]} + (ADDR_W+1)'(l);
         head_mask[l] = txt_en_mem[txt_rd_ptr][l] && (lane_end < {1'b0, TXT_SIZE});
      end
   end

   txt_state_e            state, state_nxt;
   logic [DATA_BYTES-1:0] mask, mask_nxt;
   logic [ADDR_W-1:0]     cur_off, cur_off_nxt;
   logic [DW-1:0]         cur_word, cur_word_nxt;
   logic [LANE_W-1:0]     lane;

   always_comb begin
      lane = '0;
      for (int l = DATA_BYTES - 1; l >= 0; l--) begin
         if (mask[l]) lane = LANE_W'(l);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         mask     <= '0;
         cur_off  <= '0;
         cur_word <= '0;
      end else begin
         state    <= state_nxt;
         mask     <= mask_nxt;
         cur_off  <= cur_off_nxt;
         cur_word <= cur_word_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      mask_nxt     = mask;
      cur_off_nxt  = cur_off;
      cur_word_nxt = cur_word;
      txt_pop      = 1'b0;
      case (state)
         IDLE: begin
            if (txt_cnt != '0) begin
               cur_off_nxt  = txt_off_mem[txt_rd_ptr];
               cur_word_nxt = txt_data_mem[txt_rd_ptr];
               mask_nxt     = head_mask;
               if (head_mask == '0) txt_pop = 1'b1;
               else                 state_nxt = EMIT;
            end
         end
         EMIT: begin
            if (bus.txt_ready) begin
               mask_nxt = mask & ~(DATA_BYTES'(1) << lane);
               if (mask_nxt == '0) begin
                  txt_pop   = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.txt_valid = (state == EMIT);
   assign bus.txt_addr  = cur_off + ADDR_W'(lane);
   assign bus.txt_data  = cur_word[8*lane +: 8];
   assign txt_fsm_state = state;

`ifdef MEM_TO_GFX_PERF_EN
   logic stall;
   assign stall = bus.req_write_en && (in_gfx || in_txt) && !bus.req_hit;

   always_ff @(posedge clk) begin
      if (!reset) begin
         gfx_wr_count <= '0;
         txt_wr_count <= '0;
         stall_count  <= '0;
      end else begin
         if (gfx_pop && gfx_wr_count != '1) gfx_wr_count <= gfx_wr_count + 32'd1;
         if (bus.txt_valid && bus.txt_ready && txt_wr_count != '1) txt_wr_count <= txt_wr_count + 32'd1;
         if (stall && stall_count != '1) stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule
